// File: rtl/uart_rx_core.sv
// UART receive engine: synchronizes rxd, samples each bit mid-period on the
// shared oversample tick, and hands completed words to a valid/ready register.
`timescale 1ns/1ps
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_perr,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_rxdMeta;
  logic                  r_rxdSync;
  logic [TW-1:0]         r_tcnt;
  logic [3:0]            r_bcnt;
  logic [DATA_BITS-1:0]  r_sh;
  logic                  r_framePerr;
  logic [DATA_BITS-1:0]  r_rxData;
  logic                  r_rxValid;
  logic                  r_rxPerr;
  logic                  r_frameErr;
  logic                  r_overrun;
  logic                  r_busy;

  logic w_halfHit;
  logic w_fullHit;
  logic w_deliver;
  logic w_stopLow;
  logic w_accept;
  logic w_drop;
  logic w_parErr;
  logic w_tcntClear;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxdMeta <= 1'b1;
      r_rxdSync <= 1'b1;
    end else begin
      r_rxdMeta <= rxd;
      r_rxdSync <= r_rxdMeta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (tick && !r_rxdSync) w_next = S_START;
      S_START:  if (w_halfHit) w_next = r_rxdSync ? S_IDLE : S_DATA;
      S_DATA:   if (w_fullHit && r_bcnt == LAST_BIT)
                  w_next = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (w_fullHit) w_next = S_STOP;
      S_STOP:   if (w_fullHit) w_next = r_rxdSync ? S_IDLE : S_BREAK;
      S_BREAK:  if (tick && r_rxdSync) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_halfHit   = tick && (r_tcnt == HALF_LAST) && (r_state == S_START);
    w_fullHit   = tick && (r_tcnt == FULL_LAST);
    w_deliver   = (r_state == S_STOP) && w_fullHit && r_rxdSync;
    w_stopLow   = (r_state == S_STOP) && w_fullHit && !r_rxdSync;
    w_accept    = w_deliver && (!r_rxValid || rx_ready);
    w_drop      = w_deliver && r_rxValid && !rx_ready;
    w_parErr    = (PARITY == 2) ? ~((^r_sh) ^ r_rxdSync) : ((^r_sh) ^ r_rxdSync);
    w_tcntClear = (r_state == S_IDLE) || (r_state == S_BREAK) || w_halfHit ||
                  (w_fullHit && (r_state == S_DATA || r_state == S_PARITY ||
                                 r_state == S_STOP));
  end

  // Bits arrive LSB first, so each sample enters at the MSB and shifts down
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tcnt      <= '0;
      r_bcnt      <= '0;
      r_sh        <= '0;
      r_framePerr <= 1'b0;
    end else if (tick) begin
      r_tcnt <= w_tcntClear ? '0 : r_tcnt + 1'b1;
      if (r_state == S_IDLE) begin
        r_bcnt      <= '0;
        r_framePerr <= 1'b0;
      end
      if (r_state == S_DATA && w_fullHit) begin
        r_sh   <= {r_rxdSync, r_sh[DATA_BITS-1:1]};
        r_bcnt <= r_bcnt + 1'b1;
      end
      if (r_state == S_PARITY && w_fullHit) r_framePerr <= w_parErr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxData   <= '0;
      r_rxValid  <= 1'b0;
      r_rxPerr   <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_frameErr <= w_stopLow;
      r_overrun  <= w_drop;
      r_busy     <= (r_state != S_IDLE);
      if (w_accept) begin
        r_rxData  <= r_sh;
        r_rxPerr  <= r_framePerr;
        r_rxValid <= 1'b1;
      end else if (r_rxValid && rx_ready) begin
        r_rxValid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_rxData;
  assign rx_valid  = r_rxValid;
  assign rx_perr   = r_rxPerr;
  assign frame_err = r_frameErr;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed plus randomized frames into an 8N1 receiver and an 8E1 receiver,
// checked against a frame-level model of what each line waveform should yield.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int BITCLK = 16 * 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rxd0, rxd1;
  logic       rxReady0, rxReady1;
  logic [7:0] rxData0, rxData1;
  logic       rxValid0, rxValid1;
  logic       rxPerr0, rxPerr1;
  logic       frameErr0, frameErr1;
  logic       overrun0, overrun1;
  logic       busy0, busy1;

  int vectors = 0;
  int miscompares = 0;

  int         validCnt0 = 0, ferrCnt0 = 0, ovrCnt0 = 0;
  int         validCnt1 = 0, ferrCnt1 = 0, ovrCnt1 = 0;
  logic [8:0] capQ0[$];
  logic [8:0] capQ1[$];
  int         rdIdx0 = 0, rdIdx1 = 0;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .rxd(rxd0), .rx_ready(rxReady0),
    .rx_data(rxData0), .rx_valid(rxValid0), .rx_perr(rxPerr0),
    .frame_err(frameErr0), .overrun(overrun0), .busy(busy0)
  );

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .rxd(rxd1), .rx_ready(rxReady1),
    .rx_data(rxData1), .rx_valid(rxValid1), .rx_perr(rxPerr1),
    .frame_err(frameErr1), .overrun(overrun1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Tick on every third clock, changed on the falling edge
  initial begin
    int tickDiv;
    tickDiv = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tickDiv = (tickDiv == 2) ? 0 : tickDiv + 1;
      tick = (tickDiv == 0);
    end
  end

  // Monitor samples mid-low-phase, after inputs have settled for the cycle
  always begin
    @(negedge clk);
    #2;
    if (rxValid0) validCnt0++;
    if (frameErr0) ferrCnt0++;
    if (overrun0) ovrCnt0++;
    if (rxValid0 && rxReady0) capQ0.push_back({rxPerr0, rxData0});
    if (rxValid1) validCnt1++;
    if (frameErr1) ferrCnt1++;
    if (overrun1) ovrCnt1++;
    if (rxValid1 && rxReady1) capQ1.push_back({rxPerr1, rxData1});
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: time limit expired, observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: parity error means the count of ones in data plus the parity bit
  // is odd for even parity (mode 1), even for odd parity (mode 2)
  function automatic logic modelPerr(input logic [7:0] d, input logic p, input int mode);
    int ones;
    ones = $countones(d) + int'(p);
    if (mode == 0) return 1'b0;
    if (mode == 1) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic driveLine(input int which, input logic val, input int nclk);
    if (which == 0) rxd0 = val;
    else            rxd1 = val;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic applyStimulus(input int which, input logic [7:0] data,
                               input logic withPar, input logic parBit,
                               input logic stopBit);
    driveLine(which, 1'b0, BITCLK);
    for (int i = 0; i < 8; i++) driveLine(which, data[i], BITCLK);
    if (withPar) driveLine(which, parBit, BITCLK);
    driveLine(which, stopBit, BITCLK);
    driveLine(which, 1'b1, 12);
  endtask

  task automatic expectWord(input int which, input string tag,
                            input logic [7:0] d, input logic p);
    int         sz;
    int         idx;
    logic [8:0] got;
    sz  = (which == 0) ? capQ0.size() : capQ1.size();
    idx = (which == 0) ? rdIdx0 : rdIdx1;
    checkOutput({tag, "_count"}, sz, idx + 1);
    got = 'x;
    if (sz > idx) got = (which == 0) ? capQ0[idx] : capQ1[idx];
    checkOutput({tag, "_data"}, {24'd0, got[7:0]}, {24'd0, d});
    checkOutput({tag, "_perr"}, {31'd0, got[8]}, {31'd0, p});
    if (which == 0) rdIdx0 = sz;
    else            rdIdx1 = sz;
  endtask

  initial begin
    int         vBase, fBase, oBase;
    logic [7:0] rb;
    logic       rp;

    reset = 1'b0;
    rxd0 = 1'b1;
    rxd1 = 1'b1;
    rxReady0 = 1'b1;
    rxReady1 = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_valid", rxValid0, 0);
    checkOutput("rst_busy", busy0, 0);
    checkOutput("rst_data", rxData0, 0);
    checkOutput("rst_ferr", frameErr0, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Basic 8N1 frame
    vBase = validCnt0; fBase = ferrCnt0; oBase = ovrCnt0;
    applyStimulus(0, 8'hA5, 1'b0, 1'b0, 1'b1);
    checkOutput("a5_validcycles", validCnt0 - vBase, 1);
    expectWord(0, "a5", 8'hA5, 1'b0);
    checkOutput("a5_ferr", ferrCnt0 - fBase, 0);
    checkOutput("a5_ovr", ovrCnt0 - oBase, 0);
    checkOutput("a5_busy_idle", busy0, 0);

    // Short low glitch aborts from START
    vBase = validCnt0;
    driveLine(0, 1'b0, 8);
    checkOutput("glitch_busy_hi", busy0, 1);
    driveLine(0, 1'b0, 4);
    driveLine(0, 1'b1, 60);
    checkOutput("glitch_novalid", validCnt0 - vBase, 0);
    checkOutput("glitch_busy_lo", busy0, 0);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    expectWord(0, "glitch_3c", 8'h3C, 1'b0);

    // Line held low for 20 bit times
    vBase = validCnt0; fBase = ferrCnt0;
    driveLine(0, 1'b0, 20 * BITCLK);
    driveLine(0, 1'b1, 100);
    checkOutput("break_ferr", ferrCnt0 - fBase, 1);
    checkOutput("break_novalid", validCnt0 - vBase, 0);
    checkOutput("break_busy_lo", busy0, 0);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    expectWord(0, "break_3c", 8'h3C, 1'b0);

    // Overrun with consumer stalled
    oBase = ovrCnt0;
    rxReady0 = 1'b0;
    applyStimulus(0, 8'h11, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 8'h22, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr_pulses", ovrCnt0 - oBase, 1);
    checkOutput("ovr_valid", rxValid0, 1);
    checkOutput("ovr_held_data", rxData0, 8'h11);
    rxReady0 = 1'b1;
    @(negedge clk);
    #3;
    checkOutput("ovr_valid_drop", rxValid0, 0);
    expectWord(0, "ovr_consumed", 8'h11, 1'b0);

    // Even parity receiver
    applyStimulus(1, 8'h07, 1'b1, 1'b0, 1'b1);
    expectWord(1, "par_bad", 8'h07, modelPerr(8'h07, 1'b0, 1));
    applyStimulus(1, 8'h07, 1'b1, 1'b1, 1'b1);
    expectWord(1, "par_good", 8'h07, modelPerr(8'h07, 1'b1, 1));

    // Randomized frames on both receivers
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom);
      applyStimulus(0, rb, 1'b0, 1'b0, 1'b1);
      expectWord(0, "rand_8n1", rb, modelPerr(rb, 1'b0, 0));
    end
    fBase = ferrCnt1;
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom);
      rp = 1'($urandom_range(0, 1));
      applyStimulus(1, rb, 1'b1, rp, 1'b1);
      expectWord(1, "rand_8e1", rb, modelPerr(rb, rp, 1));
    end
    checkOutput("rand_8e1_noferr", ferrCnt1 - fBase, 0);

    // Reset in the middle of data bit 3
    applyStimulus(0, 8'hC3, 1'b0, 1'b0, 1'b1);
    expectWord(0, "pre_rst_c3", 8'hC3, 1'b0);
    driveLine(0, 1'b0, BITCLK);
    for (int i = 0; i < 3; i++) driveLine(0, rb[i], BITCLK);
    driveLine(0, 1'b1, BITCLK / 2);
    reset = 1'b0;
    #1;
    checkOutput("midrst_data", rxData0, 0);
    checkOutput("midrst_valid", rxValid0, 0);
    checkOutput("midrst_busy", busy0, 0);
    checkOutput("midrst_flags", {frameErr0, overrun0, rxPerr0}, 0);
    repeat (5) @(negedge clk);
    rxd0 = 1'b1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
    vBase = validCnt0; fBase = ferrCnt0; oBase = ovrCnt0;
    applyStimulus(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    expectWord(0, "post_rst_5a", 8'h5A, 1'b0);
    checkOutput("post_rst_validcycles", validCnt0 - vBase, 1);
    checkOutput("post_rst_flags", (ferrCnt0 - fBase) + (ovrCnt0 - oBase), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
